// File: rtl/cpu_defs.sv
// Encodings shared by the fetch unit and the CPU control FSM.
package cpu_defs;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned IMM_W    = 8;
  localparam int unsigned FS_W     = 3;

  localparam logic [1:0] PC_HOLD      = 2'd0;
  localparam logic [1:0] PC_INCREMENT = 2'd1;
  localparam logic [1:0] PC_REL_JUMP  = 2'd2;
  localparam logic [1:0] PC_ABS_JUMP  = 2'd3;

  localparam logic BC_ZERO  = 1'b0;
  localparam logic BC_NZERO = 1'b1;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_NOT    = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_SL     = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SR     = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_LI     = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_LW     = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_SW     = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_BIZ    = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_BNZ    = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 4'd13;
  localparam logic [OPCODE_W-1:0] OP_JMP    = 4'd14;
  localparam logic [OPCODE_W-1:0] OP_JR_EOE = 4'd15;

endpackage

// File: rtl/instruction_register.sv
// IL-gated instruction register with fixed-format field slicing.
module instruction_register
  import cpu_defs::*;
#(
  parameter int unsigned INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] data,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [REG_W-1:0]       Rd,
  output logic [REG_W-1:0]       Rs,
  output logic [REG_W-1:0]       Rt,
  output logic [IMM_W-1:0]       imm8
);

  logic [INSTR_WIDTH-1:0] ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= '0;
    end else if (load) begin
      ir_q <= data;
    end
  end

  assign opcode = ir_q[15:12];
  assign Rd     = ir_q[11:8];
  assign Rs     = ir_q[7:4];
  assign Rt     = ir_q[3:0];
  assign imm8   = ir_q[7:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction fetch and next-PC / branch resolution.
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IL,
  input  logic [1:0]             PS,
  input  logic                   BC,
  input  logic                   zero_in,
  input  logic [PC_WIDTH-1:0]    abs_target,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [PC_WIDTH-1:0]    rom_addr,
  output logic [3:0]             opcode,
  output logic [3:0]             Rd,
  output logic [3:0]             Rs,
  output logic [3:0]             Rt,
  output logic [7:0]             imm8,
  output logic [PC_WIDTH-1:0]    pc_link,
  output logic                   branch_taken,
  output logic                   halted
);

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, imm_off;
  logic                branch_taken_q, branch_taken_d;
  logic                halted_q, halted_d;
  logic                rel_cond, rel_taken;
  logic [31:0]         imm_sext;

  instruction_register #(
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_ir (
    .clk   (clk),
    .reset (reset),
    .load  (IL),
    .data  (rom_data),
    .opcode(opcode),
    .Rd    (Rd),
    .Rs    (Rs),
    .Rt    (Rt),
    .imm8  (imm8)
  );

  // Sign-extend wide, then keep the low PC_WIDTH bits (covers PC_WIDTH < 8 too).
  assign imm_sext = {{24{imm8[7]}}, imm8};
  assign imm_off  = imm_sext[PC_WIDTH-1:0];
  assign pc_inc   = pc_q + PC_WIDTH'(1);

  always_comb begin
    rel_cond       = (opcode == OP_BIZ) || (opcode == OP_BNZ);
    rel_taken      = rel_cond ? ((BC == BC_NZERO) ? ~zero_in : zero_in) : 1'b1;
    pc_d           = pc_q;
    branch_taken_d = 1'b0;
    case (PS)
      PC_HOLD:      pc_d = pc_q;
      PC_INCREMENT: pc_d = pc_inc;
      PC_REL_JUMP: begin
        pc_d           = rel_taken ? (pc_q + imm_off) : pc_inc;
        branch_taken_d = rel_taken;
      end
      PC_ABS_JUMP: begin
        pc_d           = abs_target;
        branch_taken_d = 1'b1;
      end
      default:      pc_d = pc_q;
    endcase
    halted_d = halted_q | ((opcode == OP_JR_EOE) && (Rd != '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      branch_taken_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      branch_taken_q <= branch_taken_d;
      halted_q       <= halted_d;
    end
  end

  assign rom_addr     = pc_q;
  assign pc_link      = pc_inc;
  assign branch_taken = branch_taken_q;
  assign halted       = halted_q;

endmodule
